// File: rtl/ones_pkg.sv
// Shared types for the ones index serializer: FSM states, index-width helper
// and the registered beat record.
package ones_pkg;

  localparam int WIDTH_DEF = 64;

  function automatic int idx_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int IDX_W_DEF = idx_width(WIDTH_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  typedef logic [IDX_W_DEF-1:0] idx_t;
  typedef logic [IDX_W_DEF:0]   cnt_t;

  // Sized for WIDTH_DEF; the extra count bit holds an ordinal equal to WIDTH.
  typedef struct packed {
    idx_t idx;
    cnt_t cnt;
    logic last;
    logic zero;
  } beat_t;

endpackage

// File: rtl/ones_index_serializer_if.sv
// Word-in / bit-index-out handshake bundle. master = producer+consumer side,
// slave = the serializer.
interface ones_index_serializer_if #(
  parameter int WIDTH = ones_pkg::WIDTH_DEF
);
  localparam int WIDTH2 = ones_pkg::idx_width(WIDTH);

  logic [WIDTH-1:0]  data_i;
  logic              data_val_i;
  logic              data_rdy_o;
  logic [WIDTH2-1:0] idx_o;
  logic [WIDTH2:0]   cnt_o;
  logic              idx_val_o;
  logic              idx_last_o;
  logic              zero_o;
  logic              idx_rdy_i;

  modport master (
    output data_i, data_val_i, idx_rdy_i,
    input  data_rdy_o, idx_o, cnt_o, idx_val_o, idx_last_o, zero_o
  );

  modport slave (
    input  data_i, data_val_i, idx_rdy_i,
    output data_rdy_o, idx_o, cnt_o, idx_val_o, idx_last_o, zero_o
  );

endinterface

// File: rtl/lsb_finder.sv
// Combinational priority encoder: index of the lowest set bit plus a found flag.
module lsb_finder #(
  parameter int WIDTH = 64,
  parameter int IDX_W = 6
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top so the lowest set bit is the one that sticks.
  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (data_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign found_o = |data_i;

endmodule

// File: rtl/ones_index_serializer.sv
// Walks an accepted word and emits the index of each set bit, lowest first,
// with a running 1-based ordinal; an all-zero word yields one zero beat.
module ones_index_serializer
  import ones_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int WIDTH2 = idx_width(WIDTH)
) (
  input logic                    clk_i,
  input logic                    srst_n_i,
  ones_index_serializer_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  beat_t            beat_q, beat_d;
  logic             val_q, val_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH-1:0] shadow_nxt;
  logic [WIDTH-1:0] find_in;
  idx_t             find_idx;
  logic             find_hit;
  logic             find_single;
  logic             beat_hs;

  assign beat_hs    = val_q & bus.idx_rdy_i;
  assign shadow_nxt = shadow_q & (shadow_q - WIDTH'(1));

  // One finder serves both the incoming word (first beat) and the shadow with
  // the current bit dropped (every following beat), so all beats are registered.
  assign find_in     = (state_q == IDLE) ? bus.data_i : shadow_nxt;
  assign find_single = find_hit && ((find_in & (find_in - WIDTH'(1))) == '0);

  lsb_finder #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W_DEF)
  ) u_lsb_finder (
    .data_i  (find_in),
    .idx_o   (find_idx),
    .found_o (find_hit)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    beat_d   = beat_q;
    val_d    = val_q;
    rdy_d    = rdy_q;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (rdy_q && bus.data_val_i) begin
          state_d     = EMIT;
          shadow_d    = bus.data_i;
          rdy_d       = 1'b0;
          val_d       = 1'b1;
          beat_d.idx  = find_idx;
          beat_d.cnt  = find_hit ? cnt_t'(1) : cnt_t'(0);
          beat_d.last = find_single | ~find_hit;
          beat_d.zero = ~find_hit;
        end
      end
      EMIT: begin
        if (beat_hs) begin
          if (beat_q.last) begin
            state_d  = IDLE;
            val_d    = 1'b0;
            rdy_d    = 1'b1;
            beat_d   = '0;
            shadow_d = '0;
          end else begin
            shadow_d    = shadow_nxt;
            beat_d.idx  = find_idx;
            beat_d.cnt  = beat_q.cnt + cnt_t'(1);
            beat_d.last = find_single;
            beat_d.zero = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      beat_q   <= '0;
      val_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      beat_q   <= beat_d;
      val_q    <= val_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.data_rdy_o = rdy_q;
  assign bus.idx_val_o  = val_q;
  assign bus.idx_o      = beat_q.idx;
  assign bus.cnt_o      = beat_q.cnt;
  assign bus.idx_last_o = beat_q.last;
  assign bus.zero_o     = beat_q.zero;

endmodule

// File: tb/tb_ones_index_serializer.sv
// Directed and random-word bench for ones_index_serializer.
module tb_ones_index_serializer;
  import ones_pkg::*;

  localparam int W = 64;

  logic clk    = 1'b0;
  logic srst_n = 1'b0;
  always #5 clk = ~clk;

  ones_index_serializer_if #(.WIDTH(W)) bus ();

  ones_index_serializer #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .srst_n_i (srst_n),
    .bus      (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_q[$];
  logic [63:0] last_cnt_seen;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready, 1: ready toggles 1,0,1,0..., 2: random ready.
  task automatic run_word(input logic [63:0] w, input int mode);
    int   n, k, cyc, waitc;
    logic rdy, fin, done;
    n = exp_q.size();
    waitc = 0;
    while (!bus.data_rdy_o && waitc < 10) begin
      step();
      waitc++;
    end
    check_val("accept_rdy", bus.data_rdy_o, 1);
    bus.data_i     = w;
    bus.data_val_i = 1'b1;
    bus.idx_rdy_i  = 1'b0;
    step();
    bus.data_val_i = 1'b0;
    check_val("first_val", bus.idx_val_o, 1);
    k = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 400) begin
      if (!bus.idx_val_o) begin
        check_val("val_drop", bus.idx_val_o, 1);
        cyc = 400;
      end else begin
        if (n == 0) begin
          check_val("zero_idx", bus.idx_o, 0);
          check_val("zero_cnt", bus.cnt_o, 0);
          check_val("zero_last", bus.idx_last_o, 1);
          check_val("zero_flag", bus.zero_o, 1);
        end else begin
          check_val("idx", bus.idx_o, exp_q[k]);
          check_val("cnt", bus.cnt_o, k + 1);
          check_val("last", bus.idx_last_o, (k == n - 1));
          check_val("zero", bus.zero_o, 0);
        end
        check_val("rdy_in_emit", bus.data_rdy_o, 0);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2 == 0);
          default: rdy = 1'(($urandom_range(0, 1)));
        endcase
        fin = rdy && (n == 0 || k == n - 1);
        if (fin) last_cnt_seen = 64'(bus.cnt_o);
        bus.idx_rdy_i  = rdy;
        bus.data_val_i = !fin;
        bus.data_i     = {$urandom, $urandom};
        step();
        if (rdy) begin
          if (fin) done = 1'b1;
          else k++;
        end
        cyc++;
      end
    end
    check_val("word_done", done, 1);
    bus.idx_rdy_i  = 1'b0;
    bus.data_val_i = 1'b0;
    check_val("post_val", bus.idx_val_o, 0);
    check_val("post_rdy", bus.data_rdy_o, 1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    bus.data_i     = '0;
    bus.data_val_i = 1'b0;
    bus.idx_rdy_i  = 1'b0;
    last_cnt_seen  = '0;

    // Reset held for three cycles.
    srst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_rdy", bus.data_rdy_o, 0);
      check_val("rst_val", bus.idx_val_o, 0);
      check_val("rst_last", bus.idx_last_o, 0);
      check_val("rst_zero", bus.zero_o, 0);
      check_val("rst_idx", bus.idx_o, 0);
      check_val("rst_cnt", bus.cnt_o, 0);
    end
    srst_n = 1'b1;
    step();
    check_val("rel_rdy", bus.data_rdy_o, 1);
    check_val("rel_val", bus.idx_val_o, 0);

    // 0x29 -> bits 0,3,5.
    exp_q = {};
    exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(5);
    run_word(64'h29, 0);
    check_val("w29_cnt", last_cnt_seen, 3);

    // Zero word, then MSB only.
    exp_q = {};
    run_word(64'h0, 0);
    exp_q = {};
    exp_q.push_back(63);
    run_word(64'h8000_0000_0000_0000, 0);
    check_val("msb_cnt", last_cnt_seen, 1);

    // All ones with alternating back-pressure.
    exp_q = {};
    for (int i = 0; i < 64; i++) exp_q.push_back(i);
    run_word({64{1'b1}}, 1);
    check_val("ones_cnt", last_cnt_seen, 64);

    // Reset in the middle of 0xFF, coinciding with the handshake of beat idx 3.
    bus.data_i     = 64'hFF;
    bus.data_val_i = 1'b1;
    bus.idx_rdy_i  = 1'b1;
    step();
    bus.data_val_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("mid_idx", bus.idx_o, i);
      check_val("mid_cnt", bus.cnt_o, i + 1);
      step();
    end
    check_val("mid_idx3", bus.idx_o, 3);
    srst_n = 1'b0;
    step();
    check_val("mid_rst_val", bus.idx_val_o, 0);
    check_val("mid_rst_last", bus.idx_last_o, 0);
    check_val("mid_rst_cnt", bus.cnt_o, 0);
    check_val("mid_rst_rdy", bus.data_rdy_o, 0);
    srst_n        = 1'b1;
    bus.idx_rdy_i = 1'b0;
    step();
    check_val("mid_rel_rdy", bus.data_rdy_o, 1);
    exp_q = {};
    exp_q.push_back(1);
    run_word(64'h2, 0);
    check_val("w2_cnt", last_cnt_seen, 1);

    // Random words with random back-pressure against a bit-walk model.
    for (int r = 0; r < 32; r++) begin
      w = {$urandom, $urandom};
      exp_q = {};
      for (int b = 0; b < 64; b++) if (w[b]) exp_q.push_back(b);
      run_word(w, 2);
      check_val("rand_popcnt", last_cnt_seen, 64'($countones(w)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ones_index_serializer.md
Name: ones_index_serializer

Overview:
- Complement of the ones counter: instead of reducing a word to its number of set bits, it walks the word and emits the index of every set bit, one per beat, in ascending order.
- Each beat also carries a running ordinal; on the final beat that ordinal equals the popcount of the word.
- Sits between a word producer (valid/ready) and a consumer of bit positions (valid/ready with last), e.g. a sparse-mask walker feeding per-lane requests.

Parameters:
- WIDTH, 64, input word width in bits (must be at least 2).
- WIDTH2, $clog2(WIDTH), index width; the count is WIDTH2+1 bits.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- srst_n_i  in  1  synchronous reset, active-low.
- data_i  in  WIDTH  word to serialize.
- data_val_i  in  1  data_i valid.
- data_rdy_o  out  1  block can accept a word.
- idx_o  out  WIDTH2  index of the current set bit (0 = LSB).
- cnt_o  out  WIDTH2+1  1-based ordinal of the current beat; 0 on a zero-word beat.
- idx_val_o  out  1  beat valid.
- idx_last_o  out  1  final beat of the word.
- zero_o  out  1  input word was all zeros; single beat.
- idx_rdy_i  in  1  consumer accepts the beat.

Behaviour:
- Reset (srst_n_i=0 at a clock edge):
  - state goes to IDLE; shadow register cleared.
  - data_rdy_o=0, idx_val_o=0, idx_last_o=0, zero_o=0, idx_o=0, cnt_o=0.
  - data_rdy_o returns to 1 on the first cycle after reset is released.
- FSM states: IDLE, EMIT.
- IDLE:
  - data_rdy_o=1, idx_val_o=0.
  - Accept occurs when data_val_i and data_rdy_o are both high: latch data_i into the shadow register, move to EMIT.
- EMIT:
  - data_rdy_o=0.
  - All beat outputs come from registers. The first beat is valid the cycle after accept (latency 1).
  - Each beat presents: idx_o = lowest set bit of the shadow; cnt_o = beats so far + 1; idx_last_o = 1 if the shadow has exactly one set bit.
  - Beat handshake (idx_val_o and idx_rdy_i both high):
    - clear that bit in the shadow and increment cnt.
    - if the beat was last, go to IDLE (idx_val_o=0 next cycle); otherwise present the next beat on the next cycle.
  - Throughput: 1 beat per cycle while idx_rdy_i=1.
  - Back-pressure: while idx_val_o=1 and idx_rdy_i=0, idx_o, cnt_o, idx_last_o and zero_o are held stable.
- Zero word: exactly one beat with idx_val_o=1, zero_o=1, idx_last_o=1, idx_o=0, cnt_o=0.
- All-ones word: WIDTH beats with idx 0..WIDTH-1; the last beat has cnt_o=WIDTH, which needs the extra count bit.
- Word spacing: data_rdy_o rises only in the cycle after the last handshake, so there is one idle cycle between words.
- data_i and data_val_i are ignored in EMIT.
- Reset mid-burst: remaining beats are dropped and no last is emitted. The consumer must treat reset as a flush.
- Simultaneous reset and handshake: reset wins.
- Width rules:
  - cnt_o never wraps (at most WIDTH).
  - idx_o is at most WIDTH-1.
  - Arithmetic is unsigned.

Decomposition:
- Package ones_pkg holds:
  - state enum typedef {IDLE, EMIT};
  - a function returning the index width for a given WIDTH;
  - a beat struct typedef {idx, cnt, last, zero}.
- One sub-module, lsb_finder: combinational WIDTH-to-index priority encoder with a found flag, reused on the shadow register.
- Top level holds the FSM, shadow register, count register and output registers.

Test Plan:
- Reset: hold srst_n_i=0 for 3 cycles, then release -> all outputs 0 during reset; data_rdy_o=1 the cycle after release.
- Word 0x0000_0000_0000_0029, idx_rdy_i=1 -> beats idx 0,3,5 with cnt 1,2,3; last only on idx 5; first beat 1 cycle after accept.
- Word 0, then word 0x8000_0000_0000_0000 -> single zero beat (zero_o=1, last=1, cnt 0); then one beat idx 63, cnt 1, last=1.
- Word all ones with idx_rdy_i toggling 1,0,1,0 -> 64 beats idx 0..63 with no skips or duplicates; outputs stable while stalled; last has cnt 64.
- Reset mid-burst: word 0xFF, drop srst_n_i after beat 3 -> idx_val_o=0 next cycle, no last; the next word 0x2 yields idx 1, cnt 1, last.
- Random scoreboard: 32 random 64-bit words, random back-pressure -> each word's index set equals its set bits, and last-beat cnt_o equals $countones(word).
